// File: rtl/video_term_pkg.sv
// Shared definitions for the video terminal input path: default widths,
// handshake timing and the character-handshake FSM state encoding.
package video_term_pkg;

    localparam int VT_DATA_W     = 7;
    localparam int VT_ACK_CYCLES = 4;

    typedef logic [1:0] vt_state_t;

    // state       | meaning
    // ST_IDLE     | waiting for das; rda = ~full; counts stall cycles when full
    // ST_CAPTURE  | one cycle, rd written into FIFO, rda low
    // ST_ACK      | rda held low until ACK_CYCLES low cycles have elapsed
    // ST_WAIT_DA_LOW | das still high after ack; wait for it to drop
    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_CAPTURE     = 2'd1;
    localparam logic [1:0] ST_ACK         = 2'd2;
    localparam logic [1:0] ST_WAIT_DA_LOW = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with a registered head (no fall-through): head_data and
// head_valid change the cycle after a pop or after a push into an empty FIFO.
// Occupancy includes the entry currently presented on the head.
module sync_fifo #(
    parameter int DATA_W = 7,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic                       head_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_next;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;
    logic [CNT_W-1:0]  remain;

    // full is taken from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_next = rd_ptr + PTR_W'(1);
    assign remain  = count - CNT_W'(pop_ok);

    // Storage write; a push coinciding with flush is discarded.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_next;
            end
            count <= remain + CNT_W'(push_ok);
            if (pop_ok || (push_ok && empty)) begin
                head_valid <= (remain != '0) || push_ok;
                // With nothing left behind the head, the new head is the
                // character being pushed right now (not yet in storage).
                if (remain != '0) begin
                    head_data <= mem[rd_next];
                end else if (push_ok) begin
                    head_data <= push_data;
                end
            end
        end
    end

endmodule

// File: rtl/video_char_buffer.sv
// Input stage of the video terminal: synchronises the PIA data-available
// strobe, runs the rda acknowledge handshake and buffers characters in a
// FIFO presented to the display core as a valid/ready stream.
module video_char_buffer
    import video_term_pkg::*;
#(
    parameter int DATA_W      = VT_DATA_W,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_CYCLES  = VT_ACK_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          rd,
    input  logic                       da,
    output logic                       rda,
    input  logic                       flush,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overrun
);

    localparam int ACK_W       = $clog2(ACK_CYCLES+1);
    localparam int STALL_LIMIT = DEPTH * ACK_CYCLES;
    localparam int STALL_W     = $clog2(STALL_LIMIT+1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   das;
    vt_state_t              state;
    vt_state_t              state_next;
    logic [ACK_W-1:0]       ack_tmr;
    logic [STALL_W-1:0]     stall_tmr;
    logic                   ack_done;
    logic                   stalling;
    logic                   rda_int;
    logic                   push;
    logic                   full;

    // da synchroniser; das is the last stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], da};
        end
    end

    assign das      = sync_q[SYNC_STAGES-1];
    assign ack_done = (ack_tmr == '0);
    assign stalling = (state == ST_IDLE) && das && full;

    // Handshake next-state, rda level and FIFO write strobe.
    always_comb begin
        state_next = state;
        rda_int    = 1'b0;
        push       = 1'b0;
        case (state)
            ST_IDLE: begin
                rda_int = !full;
                if (das && !full) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE, ST_ACK: begin
                push = (state == ST_CAPTURE);
                if (!ack_done) begin
                    state_next = ST_ACK;
                end else if (das) begin
                    state_next = ST_WAIT_DA_LOW;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_DA_LOW: begin
                rda_int = !full;
                if (!das) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // rda is forced low while reset is held so the PIA only sees it rise
    // once the block is out of reset.
    assign rda = !rst && rda_int;

    // State register; flush deliberately leaves the handshake running.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ack down-counter: remaining low cycles after the current one, loaded
    // on CAPTURE entry so the low time includes the CAPTURE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_tmr <= '0;
        end else if ((state == ST_IDLE) && (state_next == ST_CAPTURE)) begin
            ack_tmr <= ACK_W'(ACK_CYCLES - 1);
        end else if (((state == ST_CAPTURE) || (state == ST_ACK)) && !ack_done) begin
            ack_tmr <= ack_tmr - ACK_W'(1);
        end
    end

    // Stall down-counter: reloads whenever not stalling, saturates at zero.
    always_ff @(posedge clk) begin
        if (rst || flush || !stalling) begin
            stall_tmr <= STALL_W'(STALL_LIMIT);
        end else if (stall_tmr != '0) begin
            stall_tmr <= stall_tmr - STALL_W'(1);
        end
    end

    // Sticky overrun, set on the last cycle of a full stall window.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            overrun <= 1'b0;
        end else if (stalling && (stall_tmr == STALL_W'(1))) begin
            overrun <= 1'b1;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .push_data  (rd),
        .pop        (out_ready),
        .head_data  (out_data),
        .head_valid (out_valid),
        .count      (count),
        .full       (full)
    );

endmodule

// File: tb/tb_video_char_buffer.sv
// Directed bench for video_char_buffer with default parameters
// (DATA_W=7, DEPTH=16, SYNC_STAGES=2, ACK_CYCLES=4). Inputs are driven and
// outputs sampled on the falling edge; consumed characters are logged at
// the rising edge when out_valid and out_ready are both high.
module tb_video_char_buffer;

    localparam int DATA_W = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] rd;
    logic              da;
    logic              rda;
    logic              flush;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        count;
    logic              overrun;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] got[$];

    always #5 clk = ~clk;

    video_char_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .rd        (rd),
        .da        (da),
        .rda       (rda),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overrun   (overrun)
    );

    // Log every character the display side actually takes.
    always @(posedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            got.push_back(out_data);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_char(input logic [DATA_W-1:0] v);
        rd = v;
        da = 1'b1;
        tick(8);
        da = 1'b0;
        tick(5);
    endtask

    function automatic int got_at(input int i);
        if (i < got.size()) return int'(got[i]);
        return -1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_cnt;
        int first_low;
        int valid_cnt;
        logic rda_mid;

        rst = 1'b1; da = 1'b0; flush = 1'b0; out_ready = 1'b0; rd = '0;
        tick(3);
        check("rst_rda", 32'(rda), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_count", 32'(count), 0);
        check("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        tick(1);
        check("post_rst_rda", 32'(rda), 1);

        // Single character: rda low cycles 3..6 after da, one valid pulse.
        got.delete();
        out_ready = 1'b1; rd = 7'h41; da = 1'b1;
        low_cnt = 0; first_low = -1; valid_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (!rda) begin
                low_cnt++;
                if (first_low < 0) first_low = i;
            end
            if (out_valid) valid_cnt++;
        end
        da = 1'b0;
        tick(6);
        check("t1_first_low", first_low, 3);
        check("t1_low_cycles", low_cnt, 4);
        check("t1_valid_pulses", valid_cnt, 1);
        check("t1_nchars", got.size(), 1);
        check("t1_data", got_at(0), 32'h41);
        check("t1_count", 32'(count), 0);
        check("t1_rda_idle", 32'(rda), 1);

        // Held da: one capture, rda back high while waiting for da low.
        got.delete();
        rd = 7'h22; da = 1'b1; low_cnt = 0; rda_mid = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            tick(1);
            if (!rda) low_cnt++;
            if (i == 50) rda_mid = rda;
        end
        da = 1'b0;
        tick(6);
        check("t2_low_cycles", low_cnt, 4);
        check("t2_rda_wait", 32'(rda_mid), 1);
        check("t2_nchars", got.size(), 1);
        check("t2_data", got_at(0), 32'h22);

        // Fill to full, stall a 17th character, then drain.
        got.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_char(DATA_W'(8'h30 + i));
        check("t3_count_full", 32'(count), 16);
        check("t3_valid", 32'(out_valid), 1);
        check("t3_head", 32'(out_data), 32'h30);
        check("t3_rda_full", 32'(rda), 0);
        rd = 7'h40; da = 1'b1;
        tick(30);
        check("t3_overrun_early", 32'(overrun), 0);
        check("t3_rda_stall", 32'(rda), 0);
        check("t3_count_stall", 32'(count), 16);
        tick(50);
        check("t3_overrun_set", 32'(overrun), 1);
        out_ready = 1'b1;
        tick(40);
        da = 1'b0;
        tick(10);
        check("t3_nchars", got.size(), 17);
        for (int i = 0; i < 17; i++) check("t3_order", got_at(i), 32'h30 + i);
        check("t3_overrun_sticky", 32'(overrun), 1);
        check("t3_count_drained", 32'(count), 0);

        // Simultaneous push and pop at count 5, then 40 chars through.
        got.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_char(DATA_W'(8'h50 + i));
        check("t4_count5", 32'(count), 5);
        rd = 7'h55; da = 1'b1;
        tick(3);
        check("t4_pre_count", 32'(count), 5);
        out_ready = 1'b1;
        tick(1);
        check("t4_pushpop_count", 32'(count), 5);
        tick(1);
        check("t4_pop_count", 32'(count), 4);
        tick(6);
        da = 1'b0;
        tick(5);
        for (int i = 6; i < 40; i++) send_char(DATA_W'(8'h50 + i));
        tick(5);
        check("t4_nchars", got.size(), 40);
        for (int i = 0; i < 40; i++) check("t4_order", got_at(i), 32'h50 + i);
        check("t4_count_end", 32'(count), 0);

        // Flush during ACK with count 3.
        got.delete();
        out_ready = 1'b0;
        send_char(7'h11);
        send_char(7'h12);
        check("t5_count2", 32'(count), 2);
        check("t5_overrun_before", 32'(overrun), 1);
        rd = 7'h13; da = 1'b1;
        tick(4);
        check("t5_count3", 32'(count), 3);
        check("t5_rda_ack", 32'(rda), 0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("t5_flush_count", 32'(count), 0);
        check("t5_flush_valid", 32'(out_valid), 0);
        check("t5_flush_overrun", 32'(overrun), 0);
        check("t5_rda_low5", 32'(rda), 0);
        tick(1);
        check("t5_rda_low6", 32'(rda), 0);
        tick(1);
        check("t5_rda_rise", 32'(rda), 1);
        da = 1'b0;
        tick(6);
        check("t5_count_end", 32'(count), 0);
        check("t5_valid_end", 32'(out_valid), 0);

        // Reset during CAPTURE: no write, outputs at reset values.
        got.delete();
        out_ready = 1'b1; rd = 7'h66; da = 1'b1;
        tick(3);
        check("t6_rda_capture", 32'(rda), 0);
        rst = 1'b1; da = 1'b0;
        tick(1);
        check("t6_rst_rda", 32'(rda), 0);
        check("t6_rst_valid", 32'(out_valid), 0);
        check("t6_rst_data", 32'(out_data), 0);
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        tick(6);
        check("t6_count_after", 32'(count), 0);
        check("t6_valid_after", 32'(out_valid), 0);
        check("t6_rda_after", 32'(rda), 1);
        check("t6_nchars", got.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
